// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low cathode patterns (bit7 = DP, bits6..0 = g..a),
// capture FSM states and the decoded-digit payload.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic               illegal;
        logic [DIGIT_W-1:0] value;
    } bcd_t;

    // Forward mapping used by the display driver; DP is left dark.
    function automatic logic [7:0] bcd_to_seg(input logic [DIGIT_W-1:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Inverse segment lookup: 7-bit g..a pattern to BCD value, flagging anything that is not 0..9.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output bcd_t       o_bcd_c
);

    always_comb begin
        o_bcd_c.illegal = 1'b0;
        o_bcd_c.value   = 4'd0;
        case (i_seg)
            SEG_0[6:0]: o_bcd_c.value = 4'd0;
            SEG_1[6:0]: o_bcd_c.value = 4'd1;
            SEG_2[6:0]: o_bcd_c.value = 4'd2;
            SEG_3[6:0]: o_bcd_c.value = 4'd3;
            SEG_4[6:0]: o_bcd_c.value = 4'd4;
            SEG_5[6:0]: o_bcd_c.value = 4'd5;
            SEG_6[6:0]: o_bcd_c.value = 4'd6;
            SEG_7[6:0]: o_bcd_c.value = 4'd7;
            SEG_8[6:0]: o_bcd_c.value = 4'd8;
            SEG_9[6:0]: o_bcd_c.value = 4'd9;
            default:    o_bcd_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit seven-segment bus and recovers per-digit BCD values once a
// digit's pattern has been stable long enough; stale digits lose valid after a timeout.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        update
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LOAD     = TO_W'(TIMEOUT_CYCLES);
    localparam bit               SINGLE      = (STABLE_CYCLES == 1);

    logic [3:0]       r_an;
    logic [7:0]       r_seg;
    cap_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx;
    logic [7:0]       r_pat, w_pat_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_sel, w_same, w_start, w_cap;
    bcd_t             w_bcd;

    logic [15:0]      r_digits;
    logic [3:0]       r_dp, r_valid, r_err;
    logic             r_update;
    logic [TO_W-1:0]  r_to [NUM_DIGITS];

    seg7_to_bcd u_dec (
        .i_seg   (r_seg[6:0]),
        .o_bcd_c (w_bcd)
    );

    // One-cold anode decode; anything else is blanking.
    always_comb begin
        w_sel = 1'b1;
        w_idx = '0;
        case (r_an)
            4'b1110: w_idx = IDX_W'(0);
            4'b1101: w_idx = IDX_W'(1);
            4'b1011: w_idx = IDX_W'(2);
            4'b0111: w_idx = IDX_W'(3);
            default: w_sel = 1'b0;
        endcase
    end

    assign w_same = (w_idx == r_idx) && (r_seg == r_pat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an    <= 4'hF;
            r_seg   <= SEG_BLANK;
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pat   <= SEG_BLANK;
            r_cnt   <= '0;
        end else begin
            r_an    <= an;
            r_seg   <= seg;
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pat   <= w_pat_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stability tracker; w_start (re)opens a track on a new selected sample.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pat_nxt   = r_pat;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: w_start = w_sel;
            ST_TRACK: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_same) begin
                    if (r_cnt + CNT_W'(1) == STABLE_LAST) begin
                        w_cap       = 1'b1;
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = STABLE_LAST;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_start = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_same) begin
                    w_start = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_start) begin
            w_idx_nxt = w_idx;
            w_pat_nxt = r_seg;
            w_cnt_nxt = CNT_W'(1);
            if (SINGLE) begin
                w_cap       = 1'b1;
                w_state_nxt = ST_HOLD;
            end else begin
                w_state_nxt = ST_TRACK;
            end
        end
    end

    // Capture writes and per-digit timeouts; a capture outranks expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_valid  <= '0;
            r_err    <= '0;
            r_update <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_to[i] <= '0;
        end else begin
            r_update <= w_cap;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_cap && (w_idx == IDX_W'(i))) begin
                    r_digits[DIGIT_W*i +: DIGIT_W] <= w_bcd.illegal ? 4'd0 : w_bcd.value;
                    r_dp[i]    <= ~r_seg[7];
                    r_valid[i] <= 1'b1;
                    r_err[i]   <= w_bcd.illegal;
                    r_to[i]    <= TO_LOAD;
                end else if (r_to[i] != '0) begin
                    r_to[i] <= r_to[i] - TO_W'(1);
                    if (r_to[i] == TO_W'(1)) r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign digits = r_digits;
    assign dp     = r_dp;
    assign valid  = r_valid;
    assign err    = r_err;
    assign update = r_update;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: a slow-timeout instance checked by a capture scoreboard, and a
// single-sample / 10-cycle-timeout instance for back-to-back and timeout behaviour.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic [15:0] digits, to_digits;
    logic [3:0]  dp, valid, err, to_dp, to_valid, to_err;
    logic        update, to_update;

    int n_checks = 0;
    int n_fail   = 0;

    logic [27:0] sb [$];
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_valid, m_err;
    logic [7:0]  pat_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg7_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(400000)) u_dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg),
        .digits(digits), .dp(dp), .valid(valid), .err(err), .update(update)
    );

    seg7_capture #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(10)) u_to (
        .clk(clk), .reset(reset), .an(an), .seg(seg),
        .digits(to_digits), .dp(to_dp), .valid(to_valid), .err(to_err), .update(to_update)
    );

    always #5 clk = ~clk;

    // Each update pulse of the main instance retires one expected capture snapshot.
    always @(negedge clk) begin
        if (update === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_update: got update with no capture expected, digits=%h", digits);
            end else begin
                logic [27:0] exp_s;
                exp_s = sb.pop_front();
                if ({digits, dp, valid, err} !== exp_s) begin
                    n_fail++;
                    $display("FAIL sb_capture: got digits=%h dp=%b valid=%b err=%b, want digits=%h dp=%b valid=%b err=%b",
                             digits, dp, valid, err, exp_s[27:12], exp_s[11:8], exp_s[7:4], exp_s[3:0]);
                end
            end
        end
    end

    task automatic expect_cap(input int idx, input logic [7:0] s);
        logic [3:0] v;
        logic       bad;
        logic [7:0] p;
        v   = 4'd0;
        bad = 1'b1;
        for (int k = 0; k < 10; k++) begin
            p = pat_tbl[k];
            if (p[6:0] == s[6:0]) begin
                v   = 4'(k);
                bad = 1'b0;
            end
        end
        m_digits[4*idx +: 4] = bad ? 4'd0 : v;
        m_dp[idx]    = ~s[7];
        m_valid[idx] = 1'b1;
        m_err[idx]   = bad;
        sb.push_back({m_digits, m_dp, m_valid, m_err});
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n, output int pulses);
        an     = a;
        seg    = s;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (update === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        an    = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({digits, dp, valid, err, update} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_main: got %h, want 0", {digits, dp, valid, err, update});
        end
        n_checks++;
        if ({to_digits, to_dp, to_valid, to_err, to_update} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_to: got %h, want 0", {to_digits, to_dp, to_valid, to_err, to_update});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stability;
        int p;
        hold(4'hF, 8'hFF, 3, p);
        hold(4'b1110, 8'hF9, 3, p);
        hold(4'hF, 8'hFF, 6, p);
        n_checks++;
        if (p !== 0 || update !== 1'b0) begin
            n_fail++;
            $display("FAIL stab_three_cycles: got %0d pulses, want 0", p);
        end
        expect_cap(0, 8'hA4);
        hold(4'b1110, 8'hA4, 104, p);
        n_checks++;
        if (p !== 1) begin
            n_fail++;
            $display("FAIL stab_single_pulse: got %0d pulses, want 1", p);
        end
        n_checks++;
        if (digits[3:0] !== 4'd2 || valid !== 4'b0001 || err !== 4'b0000) begin
            n_fail++;
            $display("FAIL stab_outputs: got d0=%h valid=%b err=%b, want 2 0001 0000", digits[3:0], valid, err);
        end
        hold(4'hF, 8'hFF, 3, p);
    endtask

    task automatic test_scan;
        int         p;
        logic [7:0] pats [4] = '{8'hF9, 8'hB0, 8'h99, 8'h12};
        for (int i = 0; i < 4; i++) begin
            expect_cap(i, pats[i]);
            hold(~(4'b0001 << i), pats[i], 5, p);
        end
        hold(4'hF, 8'hFF, 2, p);
        n_checks++;
        if (digits !== 16'h5431 || dp !== 4'b1000 || valid !== 4'b1111 || err !== 4'b0000) begin
            n_fail++;
            $display("FAIL scan_result: got digits=%h dp=%b valid=%b err=%b, want 5431 1000 1111 0000",
                     digits, dp, valid, err);
        end
    endtask

    task automatic test_no_capture;
        int p;
        int total = 0;
        for (int k = 0; k < 5; k++) begin
            hold(4'b1101, 8'hC0, 2, p); total += p;
            hold(4'b1101, 8'hF9, 2, p); total += p;
        end
        hold(4'b1100, 8'hA4, 10, p); total += p;
        hold(4'b1111, 8'hA4, 6, p);  total += p;
        n_checks++;
        if (total !== 0) begin
            n_fail++;
            $display("FAIL nocap_pulses: got %0d pulses, want 0", total);
        end
        n_checks++;
        if (valid !== 4'b1111 || digits !== 16'h5431) begin
            n_fail++;
            $display("FAIL nocap_state: got valid=%b digits=%h, want 1111 5431", valid, digits);
        end
    endtask

    task automatic test_illegal;
        int p;
        expect_cap(2, 8'hFF);
        hold(4'b1011, 8'hFF, 4, p);
        hold(4'hF, 8'hFF, 3, p);
        n_checks++;
        if (err !== 4'b0100 || digits[11:8] !== 4'd0 || valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_capture: got err=%b d2=%h valid=%b, want 0100 0 1x11", err, digits[11:8], valid);
        end
        expect_cap(2, 8'h02);
        hold(4'b1011, 8'h02, 4, p);
        hold(4'hF, 8'hFF, 3, p);
        n_checks++;
        if (err !== 4'b0000 || digits[11:8] !== 4'd6 || dp !== 4'b1100) begin
            n_fail++;
            $display("FAIL legal_recapture_dp: got err=%b d2=%h dp=%b, want 0000 6 1100", err, digits[11:8], dp);
        end
    endtask

    task automatic test_back_to_back;
        int         p;
        logic [9:0] hist;
        logic [3:0] ans  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] pats [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        hold(4'hF, 8'hFF, 3, p);
        hist = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                an  = ans[k];
                seg = pats[k];
            end else begin
                an  = 4'hF;
                seg = 8'hFF;
            end
            @(negedge clk);
            hist[k] = to_update;
        end
        n_checks++;
        if (hist !== 10'b0000011110) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %b, want 0000011110", hist);
        end
        n_checks++;
        if (to_digits !== 16'h3210 || to_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_digits: got digits=%h valid=%b, want 3210 1111", to_digits, to_valid);
        end
    endtask

    task automatic test_timeout;
        int p;
        hold(4'hF, 8'hFF, 12, p);
        an = 4'b1110; seg = 8'h99;
        @(negedge clk);
        an = 4'hF; seg = 8'hFF;
        repeat (10) @(negedge clk);
        n_checks++;
        if (to_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got valid0=%b on 9th cycle, want 1", to_valid[0]);
        end
        @(negedge clk);
        n_checks++;
        if (to_valid[0] !== 1'b0 || to_digits[3:0] !== 4'd4) begin
            n_fail++;
            $display("FAIL timeout_expire: got valid0=%b d0=%h, want 0 4", to_valid[0], to_digits[3:0]);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (to_valid[0] !== 1'b0 || to_digits[3:0] !== 4'd4 || to_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_saturate: got valid0=%b d0=%h err0=%b, want 0 4 0",
                     to_valid[0], to_digits[3:0], to_err[0]);
        end
        an = 4'b1110; seg = 8'hC0;
        @(negedge clk);
        an = 4'hF; seg = 8'hFF;
        repeat (9) @(negedge clk);
        an = 4'b1110; seg = 8'hF9;
        @(negedge clk);
        an = 4'hF; seg = 8'hFF;
        @(negedge clk);
        n_checks++;
        if (to_valid[0] !== 1'b1 || to_digits[3:0] !== 4'd1 || to_update !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_vs_capture: got valid0=%b d0=%h upd=%b, want 1 1 1",
                     to_valid[0], to_digits[3:0], to_update);
        end
        hold(4'hF, 8'hFF, 3, p);
    endtask

    task automatic test_reset_midway;
        int         p;
        logic [5:0] hist;
        hold(4'b0111, 8'hF8, 2, p);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({digits, dp, valid, err, update} !== 29'd0 ||
            {to_digits, to_dp, to_valid, to_err, to_update} !== 29'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got main=%h to=%h, want 0 0",
                     {digits, dp, valid, err, update}, {to_digits, to_dp, to_valid, to_err, to_update});
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_sb_pending: got %0d entries, want 0", sb.size());
        end
        m_digits = '0; m_dp = '0; m_valid = '0; m_err = '0;
        expect_cap(3, 8'hF8);
        reset = 1'b0;
        hist = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            hist[k-1] = update;
        end
        n_checks++;
        if (hist !== 6'b010000) begin
            n_fail++;
            $display("FAIL midreset_latency: got %b, want 010000", hist);
        end
        n_checks++;
        if (digits !== 16'h7000 || valid !== 4'b1000) begin
            n_fail++;
            $display("FAIL midreset_capture: got digits=%h valid=%b, want 7000 1000", digits, valid);
        end
        hold(4'hF, 8'hFF, 3, p);
    endtask

    initial begin
        m_digits = '0; m_dp = '0; m_valid = '0; m_err = '0;
        test_reset();
        test_stability();
        test_scan();
        test_no_capture();
        test_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_midway();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d captures never seen, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
